traffic_ctrl_fsm: RTL and testbench
===================================

# traffic_ctrl_fsm

Intersection sequencing FSM that sits directly upstream and downstream of the countdown timer. It issues the timer's 4-bit load value and a one-cycle restart pulse on every phase entry, then consumes the timer's `done` to advance phases. It drives main/side vehicle lights and the pedestrian walk lamp from latched car-sensor and walk-button requests.

## Interface
- `T_MAIN_GREEN`, 4'd6, minimum main-street green, in timer units
- `T_YELLOW`, 4'd2, yellow duration, used by both streets
- `T_ALL_RED`, 4'd1, all-red clearance duration
- `T_SIDE_GREEN`, 4'd5, side-street green duration
- `T_WALK`, 4'd4, walk phase duration
- `clk` in 1: system clock; single clock domain
- `rst` in 1: asynchronous, active-high reset
- `done` in 1: timer expiry, synchronous to `clk`
- `sensor` in 1: side-street car present, synchronous and debounced
- `walk_push` in 1: pedestrian button, synchronous and debounced
- `load_val` out 4: duration for the timer; valid whenever `timer_load`=1
- `timer_load` out 1: one-cycle pulse that restarts the timer with `load_val`
- `main_light` out 3: {red, yellow, green}, one-hot
- `side_light` out 3: {red, yellow, green}, one-hot
- `walk` out 1: walk lamp

## Operation
- States: MAIN_GREEN, MAIN_WAIT, MAIN_YELLOW, ALL_RED_A, SIDE_GREEN, SIDE_YELLOW, ALL_RED_B, WALK. Use a 3-bit encoding. Any illegal code returns to MAIN_GREEN.
- Lights decode from state:
  - Main is green in MAIN_GREEN and MAIN_WAIT, yellow in MAIN_YELLOW, red in all other states.
  - Side is green in SIDE_GREEN, yellow in SIDE_YELLOW, red in all other states.
  - `walk`=1 only in WALK.
- Timed states load these values: MAIN_GREEN=T_MAIN_GREEN, MAIN_YELLOW=T_YELLOW, SIDE_YELLOW=T_YELLOW, ALL_RED_A=T_ALL_RED, ALL_RED_B=T_ALL_RED, SIDE_GREEN=T_SIDE_GREEN, WALK=T_WALK.
- MAIN_WAIT is untimed: no `timer_load` is issued and `done` is ignored there.
- Transitions are taken on an *expiry*, which means `armed` && `done`:
  - MAIN_GREEN → MAIN_WAIT.
  - MAIN_WAIT → MAIN_YELLOW as soon as `side_req` | `walk_req` is set; no expiry needed.
  - MAIN_YELLOW → ALL_RED_A.
  - ALL_RED_A → SIDE_GREEN if `side_req`, otherwise WALK.
  - SIDE_GREEN → SIDE_YELLOW.
  - SIDE_YELLOW → ALL_RED_B.
  - ALL_RED_B → WALK if `walk_req`, otherwise MAIN_GREEN.
  - WALK → MAIN_GREEN.
- Request latches:
  - `side_req` is set by `sensor`=1 and cleared on the cycle SIDE_GREEN is entered.
  - `walk_req` is set by `walk_push`=1 and cleared on the cycle WALK is entered.
  - If set and clear occur in the same cycle, clear wins: the request counts as served.
- Arming:
  - `armed` clears on every state change.
  - `armed` sets the cycle after `timer_load` is asserted.
  - `done` is never acted on while `timer_load`=1 or in the first cycle of a state. This masks the timer's stale `done` level.

## Timing
- `timer_load` and `load_val` are registered:
  - `timer_load`=1 during exactly the first cycle of each timed state.
  - `load_val` holds the current state's value, and holds its previous value in MAIN_WAIT.
- Reset values while `rst`=1 (outputs respond asynchronously):
  - state = MAIN_GREEN
  - `main_light`=3'b001, `side_light`=3'b100, `walk`=0
  - `timer_load`=0, `load_val`=T_MAIN_GREEN
  - `armed`=0, both requests cleared
  - a load-pending flag set
- First cycle after `rst` deasserts: `timer_load`=1 with `load_val`=T_MAIN_GREEN.
- Expiry sampled at edge N changes state and lights at edge N. `timer_load` goes high in the cycle following edge N.
- Minimum dwell in any timed state is 3 cycles regardless of `done`: the load cycle, the arm cycle, then the expiry edge.
- Request inputs are captured on the edge where they are high, and are usable in MAIN_WAIT on the next cycle.
- Asserting `rst` mid-phase aborts immediately. Requests are lost, and the sequence restarts with a fresh MAIN_GREEN load.

## Test plan
- **Reset and idle.** Assert `rst`, release it, hold `done`=0 for 20 cycles. Require: main=001, side=100, `walk`=0, and a single `timer_load` pulse with `load_val`=6 in cycle 1.
- **Stale done masked.** Hold `done`=1 continuously from reset release. Require: MAIN_GREEN lasts exactly 3 cycles, then MAIN_WAIT is held indefinitely with no sensor and no further `timer_load`.
- **Side cycle.** Pulse `sensor` once during MAIN_GREEN, and pulse `done` 2 cycles after each `timer_load`. Require:
  - state order MAIN_YELLOW(`load_val` 2), ALL_RED_A(1), SIDE_GREEN(5), SIDE_YELLOW(2), ALL_RED_B(1), MAIN_GREEN(6);
  - `walk` never asserted;
  - `side_req` cleared.
- **Walk only.** Pulse `walk_push` in MAIN_WAIT. Require: MAIN_YELLOW → ALL_RED_A → WALK (`load_val`=4, `walk`=1, both lights red) → MAIN_GREEN.
- **Both requests.** Assert `sensor` and `walk_push` together. Require: the side phase is served, then ALL_RED_B → WALK → MAIN_GREEN.
- **Edge cases.**
  - A `walk_push` held high on the WALK entry edge leaves `walk_req`=0.
  - Asserting `rst` mid-SIDE_GREEN restores main=001 in the same cycle, and the next `timer_load` carries `load_val`=6.

Source files
------------

// File: rtl/traffic_ctrl_fsm.sv
// Intersection sequencing FSM: drives the countdown timer (load value + restart
// pulse), consumes its expiry, and decodes vehicle and pedestrian lamps from state.
module traffic_ctrl_fsm #(
  parameter logic [3:0] T_MAIN_GREEN = 4'd6,
  parameter logic [3:0] T_YELLOW     = 4'd2,
  parameter logic [3:0] T_ALL_RED    = 4'd1,
  parameter logic [3:0] T_SIDE_GREEN = 4'd5,
  parameter logic [3:0] T_WALK       = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done,
  input  logic       sensor,
  input  logic       walk_push,
  output logic [3:0] load_val,
  output logic       timer_load,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_WAIT   = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALL_RED_A   = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6,
    WALK        = 3'd7
  } state_e;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_e     state_q, state_d;
  logic       armed_q, armed_d;
  logic       side_req_q, side_req_d;
  logic       walk_req_q, walk_req_d;
  logic       load_pend_q;
  logic       timer_load_q, timer_load_d;
  logic [3:0] load_val_q, load_val_d;
  logic       expiry;
  logic       state_change;

  function automatic logic [3:0] dur_of(input state_e s);
    case (s)
      MAIN_YELLOW, SIDE_YELLOW: dur_of = T_YELLOW;
      ALL_RED_A, ALL_RED_B:     dur_of = T_ALL_RED;
      SIDE_GREEN:               dur_of = T_SIDE_GREEN;
      WALK:                     dur_of = T_WALK;
      default:                  dur_of = T_MAIN_GREEN;
    endcase
  endfunction

  // armed_q is low during the load cycle, so a stale done level from the
  // previous phase can never cause an expiry.
  assign expiry = armed_q & done;

  // NOTE: every variable driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GREEN:  if (expiry) state_d = MAIN_WAIT;
      MAIN_WAIT:   if (side_req_q | walk_req_q) state_d = MAIN_YELLOW;
      MAIN_YELLOW: if (expiry) state_d = ALL_RED_A;
      ALL_RED_A:   if (expiry) state_d = side_req_q ? SIDE_GREEN : WALK;
      SIDE_GREEN:  if (expiry) state_d = SIDE_YELLOW;
      SIDE_YELLOW: if (expiry) state_d = ALL_RED_B;
      ALL_RED_B:   if (expiry) state_d = walk_req_q ? WALK : MAIN_GREEN;
      WALK:        if (expiry) state_d = MAIN_GREEN;
      default:     state_d = MAIN_GREEN;
    endcase

    state_change = (state_d != state_q);
    armed_d      = state_change ? 1'b0 : (armed_q | timer_load_q);

    // Clear on entry beats a coincident set: the request has been served.
    side_req_d = (side_req_q | sensor)    & ~(state_change && state_d == SIDE_GREEN);
    walk_req_d = (walk_req_q | walk_push) & ~(state_change && state_d == WALK);

    timer_load_d = load_pend_q | (state_change && state_d != MAIN_WAIT);
    load_val_d   = timer_load_d ? dur_of(state_d) : load_val_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MAIN_GREEN;
      armed_q      <= 1'b0;
      side_req_q   <= 1'b0;
      walk_req_q   <= 1'b0;
      load_pend_q  <= 1'b1;
      timer_load_q <= 1'b0;
      load_val_q   <= T_MAIN_GREEN;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      side_req_q   <= side_req_d;
      walk_req_q   <= walk_req_d;
      load_pend_q  <= 1'b0;
      timer_load_q <= timer_load_d;
      load_val_q   <= load_val_d;
    end
  end

  always_comb begin
    main_light = LAMP_RED;
    side_light = LAMP_RED;
    walk       = 1'b0;
    case (state_q)
      MAIN_GREEN, MAIN_WAIT: main_light = LAMP_GREEN;
      MAIN_YELLOW:           main_light = LAMP_YELLOW;
      SIDE_GREEN:            side_light = LAMP_GREEN;
      SIDE_YELLOW:           side_light = LAMP_YELLOW;
      WALK:                  walk       = 1'b1;
      default:               ;
    endcase
  end

  assign timer_load = timer_load_q;
  assign load_val   = load_val_q;

endmodule

// File: tb/tb_traffic_ctrl_fsm.sv
// Self-checking bench for traffic_ctrl_fsm: directed vector table, multi-cycle
// handshake sequences, and randomized traffic against a phase/age reference model.
module tb_traffic_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst, done, sensor, walk_push;
  logic [3:0] load_val;
  logic       timer_load;
  logic [2:0] main_light, side_light;
  logic       walk;

  traffic_ctrl_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .sensor     (sensor),
    .walk_push  (walk_push),
    .load_val   (load_val),
    .timer_load (timer_load),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase index plus cycles-since-load age.
  localparam int MG = 0, MW = 1, MY = 2, ARA = 3, SG = 4, SY = 5, ARB = 6, WK = 7;
  int         dur_tab  [8] = '{6, 0, 2, 1, 5, 2, 1, 4};
  logic [2:0] main_tab [8] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tab [8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

  int         m_ph, m_age;
  bit         m_side, m_walk, m_tl;
  logic [3:0] m_lv;

  task automatic model_reset();
    m_ph = MG; m_age = -1; m_side = 0; m_walk = 0; m_tl = 0; m_lv = 4'd6;
  endtask

  task automatic model_edge();
    int nxt = m_ph;
    bit chg;
    if (m_ph == MW) begin
      if (m_side || m_walk) nxt = MY;
    end else if (m_age >= 1 && done) begin
      case (m_ph)
        MG:      nxt = MW;
        MY:      nxt = ARA;
        ARA:     nxt = m_side ? SG : WK;
        SG:      nxt = SY;
        SY:      nxt = ARB;
        ARB:     nxt = m_walk ? WK : MG;
        default: nxt = MG;
      endcase
    end
    chg    = (nxt != m_ph);
    m_side = (m_side | sensor)    && !(chg && nxt == SG);
    m_walk = (m_walk | walk_push) && !(chg && nxt == WK);
    if (chg) begin
      m_ph  = nxt;
      m_age = 0;
      m_tl  = (nxt != MW);
      if (m_tl) m_lv = 4'(dur_tab[nxt]);
    end else begin
      m_tl = (m_age == -1);
      m_age++;
    end
  endtask

  // One clock: advance the model with the inputs that the edge samples, then compare.
  task automatic tick();
    if (rst) model_reset();
    else     model_edge();
    @(posedge clk);
    #1;
    check("model", {main_light, side_light, walk, timer_load, load_val},
          {main_tab[m_ph], side_tab[m_ph], (m_ph == WK), m_tl, m_lv});
  endtask

  task automatic do_reset();
    rst = 1'b1; done = 1'b0; sensor = 1'b0; walk_push = 1'b0;
    #1;
    check("async_reset", {main_light, side_light, walk, timer_load, load_val}, 12'b001_100_0_0_0110);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       d, s, w;
    logic [2:0] m, sd;
    logic       wk, tl;
    logic [3:0] lv;
  } vec_t;

  vec_t       tbl [12];
  logic [3:0] exp_lv [8];
  logic [3:0] seen   [8];

  // Drive done in the arm cycle of every timed phase and collect load values.
  task automatic run_seq(input string tag, input bit sens, input bit push, input bit hold,
                         input int n_exp, input bit exp_walk);
    int since = 99;
    int got   = 0;
    bit walk_seen = 0;
    sensor = sens; walk_push = push; done = 1'b0;
    for (int c = 0; c < 300 && got < n_exp; c++) begin
      tick();
      sensor = 1'b0;
      if (!hold) walk_push = 1'b0;
      if (walk) begin
        if (hold && walk_push) begin
          check({tag, "_walk_req_on_entry"}, dut.walk_req_q, 0);
          walk_push = 1'b0;
        end
        walk_seen = 1;
      end
      if (timer_load) begin
        seen[got] = load_val;
        got++;
        since = 0;
      end else begin
        since++;
      end
      done = (since == 1);
    end
    done = 1'b0;
    check({tag, "_load_count"}, got, n_exp);
    for (int i = 0; i < n_exp && i < got; i++)
      check($sformatf("%s_load%0d", tag, i), seen[i], exp_lv[i]);
    check({tag, "_walk_seen"}, walk_seen, exp_walk);
  endtask

  initial begin
    int tl_count;
    rst = 1'b0; done = 1'b0; sensor = 1'b0; walk_push = 1'b0;
    #2;

    // Reset and idle.
    do_reset();
    tl_count = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) check("idle_first_load", {timer_load, load_val}, {1'b1, 4'd6});
      check("idle_lights", {main_light, side_light, walk}, 7'b001_100_0);
      if (timer_load) tl_count++;
    end
    check("idle_load_count", tl_count, 1);

    // Stale done masked: MAIN_WAIT held, then a sensor proves the wait state.
    do_reset();
    done = 1'b1;
    tl_count = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (timer_load) tl_count++;
    end
    check("stale_load_count", tl_count, 1);
    sensor = 1'b1;
    tick();
    sensor = 1'b0;
    tick();
    check("stale_wait_exit", {main_light, timer_load, load_val}, {3'b010, 1'b1, 4'd2});
    done = 1'b0;

    // Directed table: stale-done masking, walk-only phase, return to main.
    tbl[0]  = '{1, 0, 0, 3'b001, 3'b100, 0, 1, 4'd6};
    tbl[1]  = '{1, 0, 0, 3'b001, 3'b100, 0, 0, 4'd6};
    tbl[2]  = '{1, 0, 0, 3'b001, 3'b100, 0, 0, 4'd6};
    tbl[3]  = '{1, 0, 1, 3'b001, 3'b100, 0, 0, 4'd6};
    tbl[4]  = '{1, 0, 0, 3'b010, 3'b100, 0, 1, 4'd2};
    tbl[5]  = '{1, 0, 0, 3'b010, 3'b100, 0, 0, 4'd2};
    tbl[6]  = '{1, 0, 0, 3'b100, 3'b100, 0, 1, 4'd1};
    tbl[7]  = '{0, 0, 0, 3'b100, 3'b100, 0, 0, 4'd1};
    tbl[8]  = '{1, 0, 0, 3'b100, 3'b100, 1, 1, 4'd4};
    tbl[9]  = '{0, 0, 0, 3'b100, 3'b100, 1, 0, 4'd4};
    tbl[10] = '{1, 0, 0, 3'b001, 3'b100, 0, 1, 4'd6};
    tbl[11] = '{0, 0, 0, 3'b001, 3'b100, 0, 0, 4'd6};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      done = tbl[i].d; sensor = tbl[i].s; walk_push = tbl[i].w;
      tick();
      check($sformatf("vec%0d", i), {main_light, side_light, walk, timer_load, load_val},
            {tbl[i].m, tbl[i].sd, tbl[i].wk, tbl[i].tl, tbl[i].lv});
    end
    done = 1'b0; sensor = 1'b0; walk_push = 1'b0;

    // Side cycle.
    do_reset();
    exp_lv = '{4'd6, 4'd2, 4'd1, 4'd5, 4'd2, 4'd1, 4'd6, 4'd0};
    run_seq("side", 1'b1, 1'b0, 1'b0, 7, 1'b0);
    check("side_req_cleared", dut.side_req_q, 0);

    // Both requests.
    do_reset();
    exp_lv = '{4'd6, 4'd2, 4'd1, 4'd5, 4'd2, 4'd1, 4'd4, 4'd6};
    run_seq("both", 1'b1, 1'b1, 1'b0, 8, 1'b1);

    // walk_push held through the WALK entry edge.
    do_reset();
    exp_lv = '{4'd6, 4'd2, 4'd1, 4'd4, 4'd6, 4'd0, 4'd0, 4'd0};
    run_seq("hold", 1'b0, 1'b1, 1'b1, 5, 1'b1);

    // Reset asserted mid-SIDE_GREEN.
    do_reset();
    exp_lv = '{4'd6, 4'd2, 4'd1, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
    run_seq("abort", 1'b1, 1'b0, 1'b0, 4, 1'b0);
    tick();
    check("abort_in_side_green", {main_light, side_light}, 6'b100_001);
    rst = 1'b1;
    #1;
    check("abort_async_lights", {main_light, side_light, walk}, 7'b001_100_0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    check("abort_reload", {timer_load, load_val}, {1'b1, 4'd6});

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      done      = ($urandom_range(0, 2) == 0);
      sensor    = ($urandom_range(0, 9) == 0);
      walk_push = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else                             tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
